// File: rtl/click_pkg.sv
// Shared types for the click classifier: FSM state and the reported click-count type.
package click_pkg;

  typedef enum logic {
    IDLE,
    COUNTING
  } state_t;

  typedef logic [1:0] count_t;

endpackage

// File: rtl/window_timer.sv
// Loadable down-counter that saturates at zero; zero flag marks an expired window.
module window_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] value;

  // Load wins over decrement so a pulse on the expiry cycle restarts the window.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (enable && (value != '0)) begin
      value <= value - WIDTH'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/click_classifier.sv
// Groups one-cycle press pulses into single/double/triple clicks separated by an inter-click window.
module click_classifier
  import click_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 2500000,
  parameter int unsigned MAX_CLICKS    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_in,
  output logic       click_valid,
  output logic [1:0] click_count,
  output logic       busy
);

  localparam int unsigned TIMER_W = $clog2(WINDOW_CYCLES);
  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(WINDOW_CYCLES - 1);
  localparam count_t MAX_COUNT  = count_t'(MAX_CLICKS);
  localparam count_t LAST_COUNT = count_t'(MAX_CLICKS - 1);

  state_t state;
  count_t count;
  logic   timer_load;
  logic   timer_enable;
  logic   timer_zero;

  // A pulse that closes the sequence needs no reload; the timer is reloaded on the next opening pulse.
  always_comb begin
    timer_load   = 1'b0;
    timer_enable = 1'b0;
    if (pulse_in && ((state == IDLE) || (count != LAST_COUNT))) begin
      timer_load = 1'b1;
    end
    if ((state == COUNTING) && !pulse_in) begin
      timer_enable = 1'b1;
    end
  end

  window_timer #(
    .WIDTH(TIMER_W)
  ) u_window_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .enable    (timer_enable),
    .load_value(RELOAD),
    .zero      (timer_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      click_valid <= 1'b0;
      click_count <= '0;
      busy        <= 1'b0;
    end else begin
      click_valid <= 1'b0;
      click_count <= '0;
      case (state)
        IDLE: begin
          if (pulse_in) begin
            state <= COUNTING;
            count <= count_t'(1);
            busy  <= 1'b1;
          end
        end
        COUNTING: begin
          // A pulse takes priority over an expiring timer on the same edge.
          if (pulse_in) begin
            if (count == LAST_COUNT) begin
              click_valid <= 1'b1;
              click_count <= MAX_COUNT;
              state       <= IDLE;
              count       <= '0;
              busy        <= 1'b0;
            end else begin
              count <= count + count_t'(1);
            end
          end else if (timer_zero) begin
            click_valid <= 1'b1;
            click_count <= count;
            state       <= IDLE;
            count       <= '0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_click_classifier.sv
// Directed bench for click_classifier: deadline-based click model checked every cycle, plus literal report pins.
module tb_click_classifier;

  localparam int W = 8;
  localparam int M = 3;

  logic       clk;
  logic       reset;
  logic       pulse_in;
  logic       click_valid;
  logic [1:0] click_count;
  logic       busy;

  click_classifier #(
    .WINDOW_CYCLES(W),
    .MAX_CLICKS   (M)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pulse_in   (pulse_in),
    .click_valid(click_valid),
    .click_count(click_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a sequence stays open until either MAX clicks arrive or W edges pass since the last pulse.
  int gedge = 0;
  int base = 0;
  bit model_ok = 0;
  bit m_open = 0;
  int m_clicks = 0;
  int m_last = 0;
  bit m_valid = 0;
  int m_count = 0;
  bit m_busy = 0;

  always @(posedge clk) begin
    gedge = gedge + 1;
    if (reset) begin
      m_open = 0; m_clicks = 0; m_valid = 0; m_count = 0; model_ok = 1;
    end else begin
      m_valid = 0; m_count = 0;
      if (m_open) begin
        if (pulse_in) begin
          m_clicks = m_clicks + 1;
          m_last = gedge;
          if (m_clicks == M) begin
            m_valid = 1; m_count = m_clicks; m_open = 0;
          end
        end else if (gedge - m_last == W) begin
          m_valid = 1; m_count = m_clicks; m_open = 0;
        end
      end else if (pulse_in) begin
        m_open = 1; m_clicks = 1; m_last = gedge;
      end
    end
    m_busy = m_open;
  end

  // Report log for literal checks, indexed by scenario-relative edge.
  int n_rep = 0;
  int rep_edge = -1;
  int rep_cnt = -1;
  bit busy_hist [0:63];

  always @(negedge clk) begin
    int rel;
    rel = gedge - base;
    if (model_ok) begin
      checks = checks + 1;
      if (click_valid !== m_valid || click_count !== 2'(m_count) || busy !== m_busy) begin
        errors = errors + 1;
        $display("FAIL cycle edge=%0d: dut valid=%b count=%0d busy=%b, model valid=%0d count=%0d busy=%0d",
                 rel, click_valid, click_count, busy, m_valid, m_count, m_busy);
      end
    end
    if (click_valid === 1'b1) begin
      n_rep = n_rep + 1;
      rep_edge = rel;
      rep_cnt = int'(click_count);
    end
    if (rel >= 0 && rel < 64) busy_hist[rel] = busy;
  end

  task automatic check_lit(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual != expected) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reset held on edges 0 and 1; pulses at p0/p1/p2 (-1 = unused); extra reset at rst_e.
  task automatic run(input string name, input int p0, input int p1, input int p2, input int rst_e,
                     input int exp_n, input int exp_edge, input int exp_cnt);
    @(negedge clk);
    n_rep = 0; rep_edge = -1; rep_cnt = -1;
    base = gedge + 1;
    for (int e = 0; e < 40; e++) begin
      reset    = (e < 2) || (e == rst_e);
      pulse_in = (e == p0) || (e == p1) || (e == p2);
      @(negedge clk);
    end
    reset = 1'b0;
    pulse_in = 1'b0;
    check_lit({name, " reports"}, n_rep, exp_n);
    if (exp_n > 0) begin
      check_lit({name, " report_edge"}, rep_edge, exp_edge);
      check_lit({name, " report_count"}, rep_cnt, exp_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pulse_in = 1'b0;
    repeat (2) @(negedge clk);
    check_lit("reset valid", int'(click_valid), 0);
    check_lit("reset count", int'(click_count), 0);
    check_lit("reset busy", int'(busy), 0);

    run("single", 10, -1, -1, -1, 1, 18, 1);
    check_lit("single busy@9", int'(busy_hist[9]), 0);
    check_lit("single busy@10", int'(busy_hist[10]), 1);
    check_lit("single busy@17", int'(busy_hist[17]), 1);
    check_lit("single busy@18", int'(busy_hist[18]), 0);

    run("double", 10, 15, -1, -1, 1, 23, 2);
    run("triple", 10, 12, 14, -1, 1, 14, 3);
    check_lit("triple busy@13", int'(busy_hist[13]), 1);
    check_lit("triple busy@14", int'(busy_hist[14]), 0);

    run("pulse_at_expiry", 10, 18, -1, -1, 1, 26, 2);
    run("reset_abort", 10, 20, -1, 14, 1, 28, 1);
    run("reset_over_pulse", 10, 14, -1, 14, 0, 0, 0);
    run("pulse_on_report", 10, 19, -1, -1, 2, 27, 1);
    run("wide_pulse", 10, 11, 12, -1, 1, 12, 3);
    run("first_after_reset", 2, -1, -1, -1, 1, 10, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/click_classifier.md
CLICK_CLASSIFIER -- requirements
Module: click_classifier

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 2500000, inter-click window in clk cycles; legal range >= 2.
REQ-002 SHALL have parameter MAX_CLICKS, default 3, largest click count reported; legal range 2..3.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pulse_in  input  1  one-cycle press pulse from the button debounce/one-shot stage.
REQ-006 SHALL have port click_valid  output  1  one-cycle strobe; click_count is valid when high.
REQ-007 SHALL have port click_count  output  2  number of clicks in the completed sequence (1..MAX_CLICKS); 0 when click_valid is low.
REQ-008 SHALL have port busy  output  1  high while a sequence is open (state COUNTING).

Function
REQ-009 SHALL implement a two-state FSM: IDLE, COUNTING.
REQ-010 IDLE + pulse_in=1 SHALL move to COUNTING, set the internal count to 1 and load the timer with WINDOW_CYCLES-1.
REQ-011 COUNTING + pulse_in=1 with count < MAX_CLICKS-1 SHALL increment the count and reload the timer with WINDOW_CYCLES-1.
REQ-012 COUNTING + pulse_in=1 with count = MAX_CLICKS-1 SHALL close the sequence immediately: click_valid=1 and click_count=MAX_CLICKS in the cycle after the sampling edge, then return to IDLE.
REQ-013 COUNTING + timer=0 + pulse_in=0 SHALL close the sequence: click_valid=1 and click_count=count in the next cycle, then return to IDLE.
REQ-014 COUNTING with timer>0 and pulse_in=0 SHALL decrement the timer by 1 per cycle.
REQ-015 Latency: with no further pulse, click_valid SHALL be high exactly during the cycle following edge k+WINDOW_CYCLES, where k is the edge that sampled the last accepted pulse.
REQ-016 click_valid SHALL be high for exactly one cycle per sequence; click_count SHALL be driven 0 in all other cycles.
REQ-017 Simultaneous pulse_in=1 and timer=0 in COUNTING SHALL be treated as a pulse: the pulse is counted or closes the sequence as in REQ-011/REQ-012, and no timeout report is issued.
REQ-018 pulse_in=1 in the cycle where click_valid is high SHALL open a new sequence with count 1; the report being output is unaffected.
REQ-019 The count SHALL never exceed MAX_CLICKS and the timer SHALL never wrap below 0.
REQ-020 pulse_in wider than one cycle SHALL be counted once per high cycle, with no edge detection inside this block.
REQ-021 busy SHALL be high in every cycle in which the state is COUNTING, and low otherwise.
REQ-022 All outputs SHALL be registered, with no combinational path from pulse_in to any output.

Reset
REQ-023 reset=1 SHALL, at the next rising edge, force state=IDLE, count=0, timer=0, click_valid=0, click_count=0 and busy=0.
REQ-024 reset asserted mid-sequence SHALL abort it with no report; reset SHALL override a simultaneous pulse_in.
REQ-025 The first pulse SHALL be accepted on the first edge after reset deasserts.

Structure
REQ-026 Package click_pkg SHALL hold the FSM state enum (IDLE, COUNTING) and the 2-bit click-count typedef.
REQ-027 Timer width SHALL be $clog2(WINDOW_CYCLES), held as a localparam in the module.
REQ-028 The timer SHALL be a sub-module window_timer: a loadable down-counter with load, enable and zero-flag outputs, saturating at 0.

Verification (WINDOW_CYCLES=8, MAX_CLICKS=3)
REQ-029 Single pulse at edge 10 -> click_valid=1 and click_count=1 in the cycle after edge 18; busy high during cycles 11..18.
REQ-030 Pulses at edges 10 and 15 -> a single report, click_count=2, in the cycle after edge 23; no report after edge 18.
REQ-031 Pulses at edges 10, 12 and 14 -> click_count=3 in the cycle after edge 14, busy=0 in the following cycle, and no later report.
REQ-032 Pulse at edge 10 and second pulse at edge 18 (timer=0) -> no report at 18; count=2 reported in the cycle after edge 26.
REQ-033 Pulse at edge 10 and reset at edge 14 -> no click_valid at any time; a later pulse at edge 20 reports count=1 in the cycle after edge 28.
REQ-034 Pulse at the edge that produces the click_valid cycle -> the report keeps its old count, a new sequence opens, and count=1 is reported 8 cycles later.
